// File: rtl/exec_pkg.sv
// Shared definitions for the execute-stage issue sequencer: ALU op codes,
// sequencer states and the per-op latency / reserved-code helpers.
package exec_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_IADD  = 4'd1;
    localparam logic [3:0] OP_FADD  = 4'd2;
    localparam logic [3:0] OP_RSVD3 = 4'd3;
    localparam logic [3:0] OP_SHL   = 4'd4;
    localparam logic [3:0] OP_SHR   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_AND   = 4'd7;
    localparam logic [3:0] OP_XOR   = 4'd8;
    localparam logic [3:0] OP_FNEG  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Only the clocked FP add takes more than one cycle in the ALU.
    function automatic logic [3:0] op_latency(input logic [3:0] ctrl, input int fp_lat);
        logic [3:0] lat_s;
        if (ctrl == OP_FADD) begin
            lat_s = 4'(fp_lat);
        end else begin
            lat_s = 4'd1;
        end
        return lat_s;
    endfunction

    function automatic logic op_reserved(input logic [3:0] ctrl);
        logic rsvd_s;
        case (ctrl)
            OP_IADD, OP_FADD, OP_SHL, OP_SHR,
            OP_OR, OP_AND, OP_XOR, OP_FNEG: rsvd_s = 1'b0;
            default:                        rsvd_s = 1'b1;
        endcase
        return rsvd_s;
    endfunction

endpackage

// File: rtl/exec_issue_seq.sv
// Execute-stage sequencer: accepts one op, holds it on the ALU for its latency,
// then presents the captured result to writeback. Optional macro EXEC_PIPE_OVERLAP_EN.
module exec_issue_seq
    import exec_pkg::*;
#(
    parameter int FP_LAT = 7,
    parameter int DEST_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_ctrl,
    input  logic [31:0]       in_srcA,
    input  logic [31:0]       in_srcB,
    input  logic [DEST_W-1:0] in_dest,
    output logic [31:0]       alu_srcA,
    output logic [31:0]       alu_srcB,
    output logic [3:0]        alu_ctrl,
    input  logic [31:0]       alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic              busy
);

    state_t              state_r;
    state_t              state_s;
    logic [3:0]          cnt_r;
    logic [DEST_W-1:0]   dest_r;
    logic                rsvd_r;
    logic                in_ready_s;
    logic                accept_s;
    logic                last_s;

    // Issue-side ready: IDLE always; with overlap also DONE while writeback drains.
    always_comb begin
        in_ready_s = 1'b0;
`ifdef EXEC_PIPE_OVERLAP_EN
        if (state_r == IDLE) begin
            in_ready_s = 1'b1;
        end else if ((state_r == DONE) && out_ready) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
`else
        if (state_r == IDLE) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
`endif
    end

    assign in_ready = in_ready_s;
    assign accept_s = in_valid & in_ready_s;
    assign last_s   = (state_r == EXEC) && (cnt_r == 4'd0);
    assign busy     = (state_r != IDLE);

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = EXEC;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == 4'd0) begin
                    state_s = DONE;
                end else begin
                    state_s = EXEC;
                end
            end
            DONE: begin
                if (accept_s) begin
                    state_s = EXEC;
                end else if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Op registers, latency counter and result capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_srcA   <= 32'd0;
            alu_srcB   <= 32'd0;
            alu_ctrl   <= 4'd0;
            cnt_r      <= 4'd0;
            dest_r     <= '0;
            rsvd_r     <= 1'b0;
            out_result <= 32'd0;
            out_dest   <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (accept_s) begin
                alu_srcA <= in_srcA;
                alu_srcB <= in_srcB;
                alu_ctrl <= in_ctrl;
                dest_r   <= in_dest;
                rsvd_r   <= op_reserved(in_ctrl);
                cnt_r    <= op_latency(in_ctrl, FP_LAT) - 4'd1;
            end else if (last_s) begin
                // Reserved codes never trust the ALU output.
                out_result <= rsvd_r ? 32'd0 : alu_result;
                out_dest   <= dest_r;
                alu_ctrl   <= OP_NONE;
            end else if (state_r == EXEC) begin
                cnt_r <= cnt_r - 4'd1;
            end
            out_valid <= (state_s == DONE);
        end
    end

endmodule

// File: tb/tb_exec_issue_seq.sv
// Self-checking bench for exec_issue_seq with a behavioural ALU (clocked FP add)
// and a spec-level reference model; honours EXEC_PIPE_OVERLAP_EN if defined.
module tb_exec_issue_seq;

    localparam int FP_LAT = 7;
    localparam int DEST_W = 5;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_ctrl = 4'd0;
    logic [31:0]       in_srcA = 32'd0;
    logic [31:0]       in_srcB = 32'd0;
    logic [DEST_W-1:0] in_dest = '0;
    logic [31:0]       alu_srcA;
    logic [31:0]       alu_srcB;
    logic [3:0]        alu_ctrl;
    logic [31:0]       alu_result;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_result;
    logic [DEST_W-1:0] out_dest;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    exec_issue_seq #(.FP_LAT(FP_LAT), .DEST_W(DEST_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_srcA(in_srcA), .in_srcB(in_srcB), .in_dest(in_dest),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dest(out_dest), .busy(busy)
    );

    // ---------------- float helpers (exact for small integer values) ----------------
    function automatic real sp_to_real(input logic [31:0] x);
        real r;
        int  e;
        if (x[30:0] == 31'd0) return 0.0;
        e = int'(x[30:23]) - 127;
        r = 1.0 + real'(x[22:0]) / 8388608.0;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        if (x[31]) r = -r;
        return r;
    endfunction

    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] d;
        int          e;
        logic [7:0]  e8;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e  = int'(d[62:52]) - 1023 + 127;
        e8 = e[7:0];
        return {d[63], e8, d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return real_to_sp(sp_to_real(a) + sp_to_real(b));
    endfunction

    // ---------------- behavioural ALU ----------------
    // Reserved codes produce junk so that the sequencer's zero-forcing is visible.
    function automatic logic [31:0] alu_comb(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd1:    return a + b;
            4'd4:    return a << b[4:0];
            4'd5:    return a >> b[4:0];
            4'd6:    return a | b;
            4'd7:    return a & b;
            4'd8:    return a ^ b;
            4'd9:    return {~a[31], a[30:0]};
            default: return a ^ 32'hA5A5_5A5A;
        endcase
    endfunction

    // FP add result appears FP_LAT cycles after the inputs become stable.
    logic [31:0] fp_pipe [0:FP_LAT-1];
    always @(posedge clock) begin
        fp_pipe[0] <= fp_add(alu_srcA, alu_srcB);
        for (int i = 1; i < FP_LAT; i++) fp_pipe[i] <= fp_pipe[i-1];
    end
    assign alu_result = (alu_ctrl == 4'd2) ? fp_pipe[FP_LAT-2] : alu_comb(alu_ctrl, alu_srcA, alu_srcB);

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint unsigned sum;
        case (c)
            4'd1: begin sum = longint'(a) + longint'(b); return sum[31:0]; end
            4'd2:    return fp_add(a, b);
            4'd4:    return (b[4:0] > 5'd31) ? 32'd0 : 32'(longint'(a) * (longint'(1) << b[4:0]));
            4'd5:    return 32'(longint'(a) / (longint'(1) << b[4:0]));
            4'd6:    return a | b;
            4'd7:    return a & b;
            4'd8:    return a ^ b;
            4'd9:    return a ^ 32'h8000_0000;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] c);
        return (c == 4'd2) ? FP_LAT : 1;
    endfunction

    // ---------------- stimulus / observation tasks (called at a negedge) ----------------
    task automatic send_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [DEST_W-1:0] d, output bit ok);
        in_ctrl = c; in_srcA = a; in_srcB = b; in_dest = d; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (in_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clock);
        end
        if (ok) begin @(posedge clock); @(negedge clock); end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input logic [31:0] ea, input logic [31:0] eb, input logic [3:0] ec,
                               output int lat, output bit rdy_seen, output bit alu_moved);
        lat = 0; rdy_seen = 1'b0; alu_moved = 1'b0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) rdy_seen = 1'b1;
            if (alu_srcA !== ea || alu_srcB !== eb || alu_ctrl !== ec) alu_moved = 1'b1;
            @(posedge clock); lat++; @(negedge clock);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clock); @(negedge clock);
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++; if ({alu_srcA, alu_srcB} !== 64'd0) begin n_fail++; $display("FAIL reset alu_src: got %h want 0", {alu_srcA, alu_srcB}); end
        n_checks++; if (alu_ctrl !== 4'd0) begin n_fail++; $display("FAIL reset alu_ctrl: got %h want 0", alu_ctrl); end
        n_checks++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL reset out_result: got %h want 0", out_result); end
        n_checks++; if (out_dest !== 5'd0) begin n_fail++; $display("FAIL reset out_dest: got %h want 0", out_dest); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
        reset = 1'b0;
        @(negedge clock);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_int_add();
        bit ok, rdy, moved; int lat;
        send_op(4'd1, 32'h5, 32'h3, 5'd7, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL int_add accept: got %b want 1", ok); end
        wait_result(32'h5, 32'h3, 4'd1, lat, rdy, moved);
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL int_add latency: got %0d want 1", lat); end
        n_checks++; if (out_result !== 32'h8) begin n_fail++; $display("FAIL int_add result: got %h want 00000008", out_result); end
        n_checks++; if (out_dest !== 5'd7) begin n_fail++; $display("FAIL int_add dest: got %0d want 7", out_dest); end
        n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL int_add in_ready during exec: got %b want 0", rdy); end
        consume();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL int_add out_valid after handshake: got %b want 0", out_valid); end
    endtask

    task automatic test_fp_add();
        bit ok, rdy, moved; int lat;
        send_op(4'd2, 32'h3F80_0000, 32'h4000_0000, 5'd12, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fp_add accept: got %b want 1", ok); end
        wait_result(32'h3F80_0000, 32'h4000_0000, 4'd2, lat, rdy, moved);
        n_checks++; if (lat != FP_LAT) begin n_fail++; $display("FAIL fp_add latency: got %0d want %0d", lat, FP_LAT); end
        n_checks++; if (moved !== 1'b0) begin n_fail++; $display("FAIL fp_add alu inputs stable: got moved=%b want 0", moved); end
        n_checks++; if (out_result !== 32'h4040_0000) begin n_fail++; $display("FAIL fp_add result: got %h want 40400000", out_result); end
        n_checks++; if (out_dest !== 5'd12) begin n_fail++; $display("FAIL fp_add dest: got %0d want 12", out_dest); end
        consume();
    endtask

    task automatic test_backpressure();
        bit ok, rdy, moved; int lat; bit held_bad, rdy_bad;
        send_op(4'd8, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd9, ok);
        wait_result(32'hFFFF_0000, 32'h0F0F_0F0F, 4'd8, lat, rdy, moved);
        n_checks++; if (out_result !== 32'hF0F0_0F0F) begin n_fail++; $display("FAIL bp xor result: got %h want F0F00F0F", out_result); end
        in_ctrl = 4'd7; in_srcA = 32'h1234_5678; in_srcB = 32'h0000_00FF; in_dest = 5'd21; in_valid = 1'b1;
        held_bad = 1'b0; rdy_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); @(negedge clock);
            if (out_valid !== 1'b1 || out_result !== 32'hF0F0_0F0F || out_dest !== 5'd9) held_bad = 1'b1;
            if (in_ready !== 1'b0) rdy_bad = 1'b1;
        end
        n_checks++; if (held_bad) begin n_fail++; $display("FAIL bp hold: got %h/%0d want F0F00F0F/9", out_result, out_dest); end
        n_checks++; if (rdy_bad) begin n_fail++; $display("FAIL bp in_ready while stalled: got 1 want 0"); end
        out_ready = 1'b1;
        send_op(4'd7, 32'h1234_5678, 32'h0000_00FF, 5'd21, ok);
        out_ready = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp second accept: got %b want 1", ok); end
        wait_result(32'h1234_5678, 32'h0000_00FF, 4'd7, lat, rdy, moved);
        n_checks++; if (out_result !== 32'h0000_0078 || out_dest !== 5'd21) begin n_fail++; $display("FAIL bp second result: got %h/%0d want 00000078/21", out_result, out_dest); end
        consume();
    endtask

    task automatic test_reserved();
        bit ok, rdy, moved; int lat;
        send_op(4'd3, 32'hDEAD_BEEF, 32'h1, 5'd4, ok);
        wait_result(32'hDEAD_BEEF, 32'h1, 4'd3, lat, rdy, moved);
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL reserved latency: got %0d want 1", lat); end
        n_checks++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL reserved result: got %h want 00000000", out_result); end
        consume();
    endtask

    task automatic test_reset_mid();
        bit ok, rdy, moved, seen; int lat;
        send_op(4'd2, 32'h4040_0000, 32'h4080_0000, 5'd30, ok);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++; if ({alu_srcA, alu_srcB, alu_ctrl} !== 68'd0) begin n_fail++; $display("FAIL midreset alu outputs: got %h want 0", {alu_srcA, alu_srcB, alu_ctrl}); end
        n_checks++; if ({out_valid, out_result, out_dest} !== 38'd0) begin n_fail++; $display("FAIL midreset result outputs: got %h want 0", {out_valid, out_result, out_dest}); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset busy: got %b want 0", busy); end
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < FP_LAT + 3; i++) begin
            @(negedge clock);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL midreset stray out_valid: got 1 want 0"); end
        send_op(4'd4, 32'h1, 32'h4, 5'd3, ok);
        wait_result(32'h1, 32'h4, 4'd4, lat, rdy, moved);
        n_checks++; if (out_result !== 32'h10 || out_dest !== 5'd3) begin n_fail++; $display("FAIL midreset shl: got %h/%0d want 00000010/3", out_result, out_dest); end
        consume();
    endtask

    task automatic test_random();
        bit ok, rdy, moved; int lat; int stall;
        logic [3:0] c; logic [31:0] a, b, exp_r; logic [DEST_W-1:0] d;
        for (int n = 0; n < 40; n++) begin
            c = 4'($urandom_range(0, 15));
            if (c == 4'd2) begin
                a = real_to_sp(real'($urandom_range(1, 1000)));
                b = real_to_sp(real'($urandom_range(1, 1000)));
            end else begin
                a = $urandom; b = $urandom;
            end
            d = DEST_W'($urandom_range(0, 31));
            exp_r = ref_result(c, a, b);
            send_op(c, a, b, d, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rand[%0d] accept: got %b want 1", n, ok); end
            wait_result(a, b, c, lat, rdy, moved);
            n_checks++; if (lat != ref_latency(c)) begin n_fail++; $display("FAIL rand[%0d] latency ctrl=%0d: got %0d want %0d", n, c, lat, ref_latency(c)); end
            n_checks++; if (out_result !== exp_r) begin n_fail++; $display("FAIL rand[%0d] result ctrl=%0d: got %h want %h", n, c, out_result, exp_r); end
            n_checks++; if (out_dest !== d) begin n_fail++; $display("FAIL rand[%0d] dest: got %0d want %0d", n, out_dest, d); end
            stall = $urandom_range(0, 3);
            repeat (stall) begin @(posedge clock); @(negedge clock); end
            n_checks++; if (out_valid !== 1'b1 || out_result !== exp_r) begin n_fail++; $display("FAIL rand[%0d] hold: got %b/%h want 1/%h", n, out_valid, out_result, exp_r); end
            consume();
            n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rand[%0d] drain: got valid=%b busy=%b want 0/0", n, out_valid, busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] opa [2], opb [2], vres [2];
        int vcyc [2]; int acc, nv, gap; bit will;
`ifdef EXEC_PIPE_OVERLAP_EN
        gap = 2;
`else
        gap = 3;
`endif
        opa[0] = 32'h1; opb[0] = 32'h2; opa[1] = 32'h4; opb[1] = 32'h8;
        vres[0] = 32'd0; vres[1] = 32'd0; vcyc[0] = 0; vcyc[1] = 0;
        acc = 0; nv = 0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && nv < 2; cyc++) begin
            if (out_valid === 1'b1) begin vcyc[nv] = cyc; vres[nv] = out_result; nv++; end
            if (acc < 2) begin
                in_valid = 1'b1; in_ctrl = 4'd6; in_srcA = opa[acc]; in_srcB = opb[acc]; in_dest = 5'(acc + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            will = in_valid && in_ready;
            @(posedge clock);
            if (will) acc++;
            @(negedge clock);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if (nv != 2) begin n_fail++; $display("FAIL b2b result count: got %0d want 2", nv); end
        n_checks++; if (vres[0] !== 32'h3) begin n_fail++; $display("FAIL b2b first result: got %h want 00000003", vres[0]); end
        n_checks++; if (vres[1] !== 32'hC) begin n_fail++; $display("FAIL b2b second result: got %h want 0000000C", vres[1]); end
        n_checks++; if (vcyc[1] - vcyc[0] != gap) begin n_fail++; $display("FAIL b2b spacing: got %0d want %0d", vcyc[1] - vcyc[0], gap); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_int_add();
        test_fp_add();
        test_backpressure();
        test_reserved();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_issue_seq.md
Name: exec_issue_seq

Overview:
- Execute-stage sequencer that feeds the simple ALU and collects its result.
- Accepts one decoded op at a time from issue (valid/ready), registers the operands and drives them stably into the ALU for the op's latency.
- Captures the ALU result and presents it, with its destination tag, to writeback (valid/ready).
- Covers both the single-cycle integer/logic ops and the multi-cycle clocked FP add.

Parameters:
FP_LAT, 7, cycles the FP add/sub needs from stable inputs to valid result; legal range 1..15
DEST_W, 5, width of the destination register tag

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  issue presents an op
in_ready  out  1  sequencer can accept an op this cycle
in_ctrl  in  4  ALU op code (1 int add, 2 fp add, 4 shl, 5 shr, 6 or, 7 and, 8 xor, 9 fneg)
in_srcA  in  32  operand A
in_srcB  in  32  operand B
in_dest  in  DEST_W  destination tag
alu_srcA  out  32  operand A to ALU
alu_srcB  out  32  operand B to ALU
alu_ctrl  out  4  op code to ALU
alu_result  in  32  ALU result
out_valid  out  1  result available to writeback
out_ready  in  1  writeback accepts the result
out_result  out  32  captured result
out_dest  out  DEST_W  tag of the captured result
busy  out  1  high while state is not IDLE

Behaviour:
- Clocking: one clock; reset is asynchronous and active-high, ports named clock and reset.
- Reset values:
  - state IDLE.
  - All registered outputs 0: alu_srcA, alu_srcB, alu_ctrl, out_result, out_dest, out_valid.
  - in_ready=1 after reset deasserts.
- States: IDLE, EXEC, DONE.
- IDLE:
  - in_ready=1, alu_ctrl=0.
  - On in_valid & in_ready: load op registers, load the latency counter, go to EXEC.
- Latency:
  - in_ctrl 2: FP_LAT.
  - All other codes: 1.
  - Counter loads latency-1; counter width 4 bits.
- EXEC:
  - alu_* driven from the op registers, constant for the whole state.
  - in_ready=0.
  - Counter decrements each cycle.
  - At the edge where counter==0: capture alu_result into out_result and the tag into out_dest, set out_valid, go to DONE.
- Reserved codes 0, 3, 10-15:
  - Still spend 1 EXEC cycle.
  - out_result is forced to 0; alu_result is ignored.
- DONE:
  - out_valid=1; out_result and out_dest are held stable until the handshake.
  - On out_ready: clear out_valid and go to IDLE.
  - If out_ready stays low, hold indefinitely.
- Timing:
  - Int op accepted at edge N: out_valid is high from cycle N+2.
  - FP op accepted at edge N: out_valid is high from cycle N+1+FP_LAT.
- in_valid while not ready:
  - Ignored; issue must hold the op.
  - No input is sampled outside the accept edge.
- Reset mid-operation (EXEC or DONE):
  - Immediately returns to IDLE with all outputs at reset values.
  - The in-flight op is discarded; no out_valid pulse.
- Throughput: one op per (latency+2) cycles minimum without the optional feature.

Optional Feature:
- Macro: EXEC_PIPE_OVERLAP_EN.
- Defined:
  - In DONE with out_ready=1, in_ready=1 the same cycle.
  - A simultaneous in_valid loads the new op and goes directly to EXEC, so the result handoff and the next accept share one edge.
  - Int throughput becomes one op per 2 cycles.
- Undefined: in_ready is high only in IDLE, exactly as in Behaviour.

Decomposition:
- Shared package exec_pkg:
  - ALU op code constants (OP_IADD=1, OP_FADD=2, OP_RSVD3=3, OP_SHL=4, OP_SHR=5, OP_OR=6, OP_AND=7, OP_XOR=8, OP_FNEG=9).
  - State enum (IDLE/EXEC/DONE).
  - Function op_latency(ctrl, FP_LAT).
  - Function op_reserved(ctrl).
- No sub-module; the FSM, counter and output register stay in one module.
- The bench instantiates exec_issue_seq together with the ALU.

Test Plan:
- Int add: srcA=0x00000005, srcB=0x00000003, ctrl=1, dest=7 accepted at edge N -> out_valid from N+2, out_result=0x00000008, out_dest=7; in_ready=0 throughout.
- FP add with FP_LAT=7: srcA=0x3F800000 (1.0), srcB=0x40000000 (2.0), ctrl=2 -> alu_* stable for 7 cycles, out_result=0x40400000 (3.0) at N+8.
- Backpressure: xor 0xFFFF0000^0x0F0F0F0F with out_ready=0 for 5 cycles -> out_result=0xF0F00F0F held stable, in_valid from a second op ignored, accepted when out_ready rises.
- Reserved ctrl=3, srcA=0xDEADBEEF -> out_valid after 1 EXEC cycle, out_result=0x00000000.
- Reset asserted during FP EXEC cycle 3 -> immediately IDLE, all outputs 0, no out_valid; a following shl 0x1<<4 returns 0x00000010.
- With EXEC_PIPE_OVERLAP_EN: back-to-back ors (0x1|0x2, then 0x4|0x8, in_valid held, out_ready=1) -> results 0x3 and 0xC on out_valid 2 cycles apart; without the macro, 3 cycles apart.
